// File: rtl/redmule_tile_sequencer_if.sv
// Tile descriptor handshake between redmule_tile_sequencer (master) and the
// scheduler/streamer control path (slave).
interface redmule_tile_sequencer_if;
  logic        tile_valid;
  logic        tile_ready;
  logic [15:0] row_idx;
  logic [15:0] wcol_idx;
  logic [15:0] xcol_idx;
  logic [7:0]  row_len;
  logic [7:0]  wcol_len;
  logic [7:0]  xcol_len;
  logic        first;
  logic        last;

  modport master (
    output tile_valid, row_idx, wcol_idx, xcol_idx,
           row_len, wcol_len, xcol_len, first, last,
    input  tile_ready
  );

  modport slave (
    input  tile_valid, row_idx, wcol_idx, xcol_idx,
           row_len, wcol_len, xcol_len, first, last,
    output tile_ready
  );
endinterface

// File: rtl/redmule_tile_sequencer.sv
// Walks the RedMulE tile iteration space (rows > W cols > X cols) and issues one
// descriptor per handshake. REDMULE_TILESEQ_COUNT_EN enables the tile_cnt_o counter.
module redmule_tile_sequencer #(
  parameter int unsigned ARRAY_WIDTH  = 12,
  parameter int unsigned ARRAY_HEIGHT = 4,
  parameter int unsigned PIPE_REGS    = 3
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            clear_i,
  input  logic                            start_i,
  input  logic [15:0]                     x_rows_iter_i,
  input  logic [15:0]                     w_cols_iter_i,
  input  logic [15:0]                     x_cols_iter_i,
  input  logic [7:0]                      x_rows_lftovr_i,
  input  logic [7:0]                      w_cols_lftovr_i,
  input  logic [7:0]                      x_cols_lftovr_i,
  redmule_tile_sequencer_if.master        tile,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [31:0]                     tile_cnt_o
);

  localparam logic [7:0] ROW_FULL = 8'(ARRAY_WIDTH);
  localparam logic [7:0] COL_FULL = 8'(ARRAY_HEIGHT * (PIPE_REGS + 1));

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e      state_q, state_d;
  logic [15:0] rows_iter_q, wcols_iter_q, xcols_iter_q;
  logic [7:0]  rows_lft_q, wcols_lft_q, xcols_lft_q;
  logic [15:0] row_q, wcol_q, xcol_q;

  logic start_acc, cfg_empty, run, handshake;
  logic row_last, wcol_last, xcol_last, final_tile;

  assign run        = (state_q == RUN);
  assign start_acc  = (state_q == IDLE) && start_i && !clear_i;
  assign cfg_empty  = (x_rows_iter_i == '0) || (w_cols_iter_i == '0) || (x_cols_iter_i == '0);
  assign handshake  = run && tile.tile_ready;
  assign row_last   = (row_q  == rows_iter_q  - 16'd1);
  assign wcol_last  = (wcol_q == wcols_iter_q - 16'd1);
  assign xcol_last  = (xcol_q == xcols_iter_q - 16'd1);
  assign final_tile = row_last && wcol_last && xcol_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = cfg_empty ? DONE : RUN;
      RUN:     if (handshake && final_tile) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rows_iter_q  <= '0;
      wcols_iter_q <= '0;
      xcols_iter_q <= '0;
      rows_lft_q   <= '0;
      wcols_lft_q  <= '0;
      xcols_lft_q  <= '0;
    end else if (clear_i) begin
      rows_iter_q  <= '0;
      wcols_iter_q <= '0;
      xcols_iter_q <= '0;
      rows_lft_q   <= '0;
      wcols_lft_q  <= '0;
      xcols_lft_q  <= '0;
    end else if (start_acc) begin
      rows_iter_q  <= x_rows_iter_i;
      wcols_iter_q <= w_cols_iter_i;
      xcols_iter_q <= x_cols_iter_i;
      rows_lft_q   <= x_rows_lftovr_i;
      wcols_lft_q  <= w_cols_lftovr_i;
      xcols_lft_q  <= x_cols_lftovr_i;
    end
  end

  // The final handshake wraps all three counters, leaving them at zero for the next job.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q  <= '0;
      wcol_q <= '0;
      xcol_q <= '0;
    end else if (clear_i || start_acc) begin
      row_q  <= '0;
      wcol_q <= '0;
      xcol_q <= '0;
    end else if (handshake) begin
      if (!xcol_last) begin
        xcol_q <= xcol_q + 16'd1;
      end else begin
        xcol_q <= '0;
        if (!wcol_last) begin
          wcol_q <= wcol_q + 16'd1;
        end else begin
          wcol_q <= '0;
          row_q  <= row_last ? '0 : row_q + 16'd1;
        end
      end
    end
  end

  assign tile.tile_valid = run;
  assign tile.row_idx    = row_q;
  assign tile.wcol_idx   = wcol_q;
  assign tile.xcol_idx   = xcol_q;
  assign tile.row_len    = !run ? '0 : (row_last  && rows_lft_q  != '0) ? rows_lft_q  : ROW_FULL;
  assign tile.wcol_len   = !run ? '0 : (wcol_last && wcols_lft_q != '0) ? wcols_lft_q : COL_FULL;
  assign tile.xcol_len   = !run ? '0 : (xcol_last && xcols_lft_q != '0) ? xcols_lft_q : COL_FULL;
  assign tile.first      = run && (xcol_q == '0);
  assign tile.last       = run && xcol_last;
  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == DONE);

`ifdef REDMULE_TILESEQ_COUNT_EN
  logic [31:0] tile_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                   tile_cnt_q <= '0;
    else if (clear_i || start_acc) tile_cnt_q <= '0;
    else if (handshake)            tile_cnt_q <= tile_cnt_q + 32'd1;
  end

  assign tile_cnt_o = tile_cnt_q;
`else
  assign tile_cnt_o = '0;
`endif

endmodule

// File: tb/tb_redmule_tile_sequencer.sv
// Scoreboard bench for redmule_tile_sequencer: stimulus pushes expected descriptors,
// a negedge monitor pops and compares on every handshake.
module tb_redmule_tile_sequencer;

  typedef struct packed {
    logic [15:0] r, w, x;
    logic [7:0]  rl, wl, xl;
    logic        f, l;
  } desc_t;

  logic        clk, rst_n, clear, start;
  logic [15:0] rows_it, wcols_it, xcols_it;
  logic [7:0]  rows_lf, wcols_lf, xcols_lf;
  logic        busy, done;
  logic [31:0] tile_cnt;

  redmule_tile_sequencer_if tif ();

  redmule_tile_sequencer #(
    .ARRAY_WIDTH (12),
    .ARRAY_HEIGHT(4),
    .PIPE_REGS   (3)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clear_i        (clear),
    .start_i        (start),
    .x_rows_iter_i  (rows_it),
    .w_cols_iter_i  (wcols_it),
    .x_cols_iter_i  (xcols_it),
    .x_rows_lftovr_i(rows_lf),
    .w_cols_lftovr_i(wcols_lf),
    .x_cols_lftovr_i(xcols_lf),
    .tile           (tif),
    .busy_o         (busy),
    .done_o         (done),
    .tile_cnt_o     (tile_cnt)
  );

  int    checks = 0;
  int    errors = 0;
  desc_t sb_q[$];
  desc_t held;
  bit    stall_pending = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic desc_t cur_desc();
    desc_t d;
    d.r = tif.row_idx;  d.w = tif.wcol_idx; d.x = tif.xcol_idx;
    d.rl = tif.row_len; d.wl = tif.wcol_len; d.xl = tif.xcol_len;
    d.f = tif.first;    d.l = tif.last;
    return d;
  endfunction

  function automatic desc_t mk(input int r, w, x, rl, wl, xl, f, l);
    desc_t d;
    d.r = 16'(r);  d.w = 16'(w);  d.x = 16'(x);
    d.rl = 8'(rl); d.wl = 8'(wl); d.xl = 8'(xl);
    d.f = 1'(f);   d.l = 1'(l);
    return d;
  endfunction

  // Reference walk: full row tile = 12, full column tile = 4*(3+1) = 16.
  function automatic void push_model(input int nr, nw, nx, lr, lw, lx);
    for (int r = 0; r < nr; r++)
      for (int w = 0; w < nw; w++)
        for (int x = 0; x < nx; x++)
          sb_q.push_back(mk(r, w, x,
                            (r == nr-1 && lr != 0) ? lr : 12,
                            (w == nw-1 && lw != 0) ? lw : 16,
                            (x == nx-1 && lx != 0) ? lx : 16,
                            (x == 0), (x == nx-1)));
  endfunction

  // Monitor: a descriptor presented with ready low must be repeated unchanged next cycle.
  always @(negedge clk) begin
    desc_t cur, exp;
    if (rst_n && !clear && tif.tile_valid) begin
      cur = cur_desc();
      if (stall_pending) check("hold_stable", 80'(cur), 80'(held));
      if (tif.tile_ready) begin
        stall_pending = 0;
        if (sb_q.size() == 0) begin
          check("unexpected_tile", 80'(cur), 80'(0));
        end else begin
          exp = sb_q.pop_front();
          check("tile_desc", 80'(cur), 80'(exp));
        end
      end else begin
        held = cur;
        stall_pending = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int r, w, x, lr, lw, lx);
    rows_it = 16'(r); wcols_it = 16'(w); xcols_it = 16'(x);
    rows_lf = 8'(lr); wcols_lf = 8'(lw); xcols_lf = 8'(lx);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: conflicting start during RUN
  task automatic run_job(input int r, w, x, lr, lw, lx, input int mode, input bit use_model);
    int n;
    int k;
    logic [31:0] exp_cnt;
    n = r * w * x;
    if (use_model) push_model(r, w, x, lr, lw, lx);
    tif.tile_ready = 1'b1;
    pulse_start(r, w, x, lr, lw, lx);
    k = 1;
    check("busy_t1", 80'(busy), 80'(1));
    check("valid_t1", 80'(tif.tile_valid), 80'(n > 0));
    while (!done && k < 2000) begin
      if (mode == 1) tif.tile_ready = ((k-1) % 4 == 0) || ((k-1) % 4 == 3);
      if (mode == 2 && k == 2) begin
        start = 1'b1;
        rows_it = 16'd5; wcols_it = 16'd5; xcols_it = 16'd5;
        rows_lf = 8'd1;  wcols_lf = 8'd1;  xcols_lf = 8'd1;
      end else begin
        start = 1'b0;
      end
      tick();
      k++;
    end
    start = 1'b0;
    tif.tile_ready = 1'b1;
    check("done_seen", 80'(done), 80'(1));
    if (mode != 1) check("done_cycle", 80'(k), 80'(n + 1));
    check("sb_drain", 80'(sb_q.size()), 80'(0));
`ifdef REDMULE_TILESEQ_COUNT_EN
    exp_cnt = 32'(n);
`else
    exp_cnt = '0;
`endif
    check("tile_cnt_done", 80'(tile_cnt), 80'(exp_cnt));
    tick();
    check("done_pulse_end", 80'(done), 80'(0));
    check("busy_end", 80'(busy), 80'(0));
    check("tile_cnt_hold", 80'(tile_cnt), 80'(exp_cnt));
  endtask

  initial begin
    bit seen_done;
    rst_n = 1'b0; clear = 1'b0; start = 1'b0;
    rows_it = '0; wcols_it = '0; xcols_it = '0;
    rows_lf = '0; wcols_lf = '0; xcols_lf = '0;
    tif.tile_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", 80'(tif.tile_valid), 80'(0));
    check("rst_busy", 80'(busy), 80'(0));
    check("rst_done", 80'(done), 80'(0));
    check("rst_cnt", 80'(tile_cnt), 80'(0));
    check("rst_desc", 80'(cur_desc()), 80'(0));
    rst_n = 1'b1;
    tick();

    // Nominal 2x1x3, no leftovers
    run_job(2, 1, 3, 0, 0, 0, 0, 1'b1);

    // Leftovers, hand-computed: row_len 12,12,5,5 / xcol_len 16,7,16,7
    sb_q.push_back(mk(0, 0, 0, 12, 16, 16, 1, 0));
    sb_q.push_back(mk(0, 0, 1, 12, 16,  7, 0, 1));
    sb_q.push_back(mk(1, 0, 0,  5, 16, 16, 1, 0));
    sb_q.push_back(mk(1, 0, 1,  5, 16,  7, 0, 1));
    run_job(2, 1, 2, 5, 0, 7, 0, 1'b0);

    // W column leftover with single reduction tile: first and last both set
    run_job(1, 3, 1, 0, 9, 0, 0, 1'b1);

    // Backpressure
    run_job(1, 2, 2, 3, 0, 0, 1, 1'b1);

    // Empty job
    run_job(4, 2, 0, 0, 0, 0, 0, 1'b1);

    // Conflicting start during RUN is ignored
    run_job(2, 1, 3, 0, 0, 0, 2, 1'b1);

    // Clear while tile 3 of 6 is presented
    push_model(2, 1, 3, 0, 0, 0);
    tif.tile_ready = 1'b1;
    pulse_start(2, 1, 3, 0, 0, 0);
    repeat (3) tick();
    check("tile3_idx", 80'({tif.row_idx, tif.wcol_idx, tif.xcol_idx}), 80'({16'd1, 16'd0, 16'd0}));
    clear = 1'b1;
    tif.tile_ready = 1'b0;
    tick();
    clear = 1'b0;
    check("clr_valid", 80'(tif.tile_valid), 80'(0));
    check("clr_busy", 80'(busy), 80'(0));
    check("clr_cnt", 80'(tile_cnt), 80'(0));
    sb_q.delete();
    seen_done = 0;
    repeat (8) begin
      seen_done |= done;
      tick();
    end
    check("clr_no_done", 80'(seen_done), 80'(0));

    // Clear and start in the same cycle: clear wins
    clear = 1'b1;
    pulse_start(2, 2, 2, 0, 0, 0);
    clear = 1'b0;
    check("clr_start_busy", 80'(busy), 80'(0));
    check("clr_start_valid", 80'(tif.tile_valid), 80'(0));

    // Restart after clear begins again at (0,0,0)
    run_job(2, 1, 3, 0, 0, 0, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
